l1d_mshr_scheduler: RTL and testbench

//  Owns L1D MSHR entries: allocates mshr_id on tag-miss/hit dispatch and sequences each entry

---
 rtl/l1d_mshr_scheduler_pkg.sv | 51 +++++
 rtl/l1d_mshr_scheduler_rr_arb.sv | 60 ++++++
 rtl/l1d_mshr_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_l1d_mshr_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1d_mshr_scheduler_pkg.sv
// l1d_mshr_scheduler_pkg: entry state encoding, entry record and helpers
// shared by the L1D MSHR scheduler and its round-robin arbiter.
package l1d_mshr_scheduler_pkg;

    localparam int MSHR_NUM_DEFAULT  = 8;
    // Hazard ids are stored at a fixed width so the entry record does not
    // depend on the instance's MSHR_NUM (supports up to 256 entries).
    localparam int L1D_MSHR_ID_MAX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HZD        = 3'd1,
        ST_EVICT      = 3'd2,
        ST_EVICT_WAIT = 3'd3,
        ST_FILL       = 3'd4,
        ST_FILL_WAIT  = 3'd5,
        ST_DONE       = 3'd6
    } mshr_state_e;

    typedef struct packed {
        mshr_state_e                  state;
        logic                         need_evict;
        logic                         need_linefill;
        logic                         hzd_vld;
        logic [L1D_MSHR_ID_MAX_W-1:0] hzd_id;
    } l1d_mshr_entry_t;

    function automatic l1d_mshr_entry_t pack_l1d_mshr_entry(
        input mshr_state_e                  st,
        input logic                         need_evict,
        input logic                         need_linefill,
        input logic                         hzd_vld,
        input logic [L1D_MSHR_ID_MAX_W-1:0] hzd_id
    );
        l1d_mshr_entry_t e;
        e.state         = st;
        e.need_evict    = need_evict;
        e.need_linefill = need_linefill;
        e.hzd_vld       = hzd_vld;
        e.hzd_id        = hzd_id;
        return e;
    endfunction

    // First step of an entry once nothing older blocks it.
    function automatic mshr_state_e mshr_route(input logic need_evict, input logic need_linefill);
        if (need_evict)    return ST_EVICT;
        if (need_linefill) return ST_FILL;
        return ST_DONE;
    endfunction

endpackage

// File: rtl/l1d_mshr_scheduler_rr_arb.sv
// l1d_mshr_rr_arb: N-requester round-robin arbiter with a vld/rdy output.
// Priority starts at the index after the last grant; a grant offered while
// rdy is low is held on the same id until it is accepted.
module l1d_mshr_rr_arb #(
    parameter int N    = 8,
    parameter int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            rdy,
    output logic            vld,
    output logic [ID_W-1:0] id
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;
    logic            lock_q, lock_d;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;

    // Rotating search from the pointer; a stalled grant overrides the search.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr_q + ID_W'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        if (lock_q && req[lock_id_q]) begin
            vld = 1'b1;
            id  = lock_id_q;
        end else begin
            vld = found;
            id  = pick;
        end
        ptr_d     = (vld && rdy) ? id + ID_W'(1) : ptr_q;
        lock_d    = vld && !rdy;
        lock_id_d = id;
    end

    // Pointer and stall-hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

endmodule

// File: rtl/l1d_mshr_scheduler.sv
// l1d_mshr_scheduler: owns the L1D MSHR entries, allocates ids to new
// requests and walks each entry through hazard wait, dirty evict, linefill
// and retirement. Evict, linefill and done ports each have their own
// round-robin arbiter.
// Optional build macro L1D_MSHR_PERF_CNT_EN adds saturating perf counters.
module l1d_mshr_scheduler
    import l1d_mshr_scheduler_pkg::*;
#(
    parameter int MSHR_NUM  = MSHR_NUM_DEFAULT,
    parameter int MSHR_ID_W = $clog2(MSHR_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_vld,
    output logic                 alloc_rdy,
    output logic [MSHR_ID_W-1:0] alloc_id,
    input  logic                 alloc_need_evict,
    input  logic                 alloc_need_linefill,
    input  logic                 alloc_hzd_vld,
    input  logic [MSHR_ID_W-1:0] alloc_hzd_id,
    output logic                 evict_req_vld,
    input  logic                 evict_req_rdy,
    output logic [MSHR_ID_W-1:0] evict_req_id,
    input  logic                 evict_ack_vld,
    input  logic [MSHR_ID_W-1:0] evict_ack_id,
    output logic                 fill_req_vld,
    input  logic                 fill_req_rdy,
    output logic [MSHR_ID_W-1:0] fill_req_id,
    input  logic                 fill_ack_vld,
    input  logic [MSHR_ID_W-1:0] fill_ack_id,
    output logic                 done_vld,
    input  logic                 done_rdy,
    output logic [MSHR_ID_W-1:0] done_id,
    output logic [MSHR_ID_W:0]   occupancy,
`ifdef L1D_MSHR_PERF_CNT_EN
    output logic [31:0]          perf_alloc_cnt,
    output logic [31:0]          perf_evict_cnt,
    output logic [31:0]          perf_fill_cnt,
    output logic [31:0]          perf_hzd_stall_cnt,
`endif
    output logic                 err_unexp_ack
);

    l1d_mshr_entry_t      entry_q [MSHR_NUM];
    l1d_mshr_entry_t      entry_d [MSHR_NUM];
    logic [MSHR_NUM-1:0]  idle_vec, evict_vec, fill_vec, done_vec;
    logic [MSHR_ID_W:0]   occupancy_q, occupancy_d;
    logic                 err_q, err_d;
    logic                 alloc_fire, evict_fire, fill_fire, done_fire;
    logic                 hzd_live;

    // Per-state request vectors and lowest-free-index allocation.
    always_comb begin
        idle_vec  = '0;
        evict_vec = '0;
        fill_vec  = '0;
        done_vec  = '0;
        alloc_id  = '0;
        for (int i = 0; i < MSHR_NUM; i++) begin
            idle_vec[i]  = (entry_q[i].state == ST_IDLE);
            evict_vec[i] = (entry_q[i].state == ST_EVICT);
            fill_vec[i]  = (entry_q[i].state == ST_FILL);
            done_vec[i]  = (entry_q[i].state == ST_DONE);
        end
        for (int i = MSHR_NUM - 1; i >= 0; i--) begin
            if (idle_vec[i]) alloc_id = MSHR_ID_W'(i);
        end
        // A retiring entry is still counted busy so it cannot be reused this cycle.
        alloc_rdy  = |idle_vec;
        alloc_fire = alloc_vld && alloc_rdy;
        evict_fire = evict_req_vld && evict_req_rdy;
        fill_fire  = fill_req_vld && fill_req_rdy;
        done_fire  = done_vld && done_rdy;
        // The older entry only blocks if it is live and not leaving right now.
        hzd_live   = alloc_hzd_vld && (entry_q[alloc_hzd_id].state != ST_IDLE) &&
                     !(done_fire && (done_id == alloc_hzd_id));
    end

    l1d_mshr_rr_arb #(.N(MSHR_NUM), .ID_W(MSHR_ID_W)) u_evict_arb (
        .clk(clk), .rst(rst), .req(evict_vec), .rdy(evict_req_rdy),
        .vld(evict_req_vld), .id(evict_req_id)
    );

    l1d_mshr_rr_arb #(.N(MSHR_NUM), .ID_W(MSHR_ID_W)) u_fill_arb (
        .clk(clk), .rst(rst), .req(fill_vec), .rdy(fill_req_rdy),
        .vld(fill_req_vld), .id(fill_req_id)
    );

    l1d_mshr_rr_arb #(.N(MSHR_NUM), .ID_W(MSHR_ID_W)) u_done_arb (
        .clk(clk), .rst(rst), .req(done_vec), .rdy(done_rdy),
        .vld(done_vld), .id(done_id)
    );

    // Per-entry next state, error flag and occupancy.
    always_comb begin
        for (int i = 0; i < MSHR_NUM; i++) begin
            entry_d[i] = entry_q[i];
            case (entry_q[i].state)
                ST_IDLE: begin
                    if (alloc_fire && (alloc_id == MSHR_ID_W'(i))) begin
                        if (hzd_live)
                            entry_d[i] = pack_l1d_mshr_entry(ST_HZD, alloc_need_evict,
                                alloc_need_linefill, 1'b1, L1D_MSHR_ID_MAX_W'(alloc_hzd_id));
                        else
                            entry_d[i] = pack_l1d_mshr_entry(
                                mshr_route(alloc_need_evict, alloc_need_linefill),
                                alloc_need_evict, alloc_need_linefill, 1'b0, '0);
                    end
                end
                ST_HZD: begin
                    if (done_fire && entry_q[i].hzd_vld &&
                        (entry_q[i].hzd_id == L1D_MSHR_ID_MAX_W'(done_id))) begin
                        entry_d[i].state   = mshr_route(entry_q[i].need_evict, entry_q[i].need_linefill);
                        entry_d[i].hzd_vld = 1'b0;
                    end
                end
                ST_EVICT: begin
                    if (evict_fire && (evict_req_id == MSHR_ID_W'(i))) entry_d[i].state = ST_EVICT_WAIT;
                end
                ST_EVICT_WAIT: begin
                    if (evict_ack_vld && (evict_ack_id == MSHR_ID_W'(i)))
                        entry_d[i].state = entry_q[i].need_linefill ? ST_FILL : ST_DONE;
                end
                ST_FILL: begin
                    if (fill_fire && (fill_req_id == MSHR_ID_W'(i))) entry_d[i].state = ST_FILL_WAIT;
                end
                ST_FILL_WAIT: begin
                    if (fill_ack_vld && (fill_ack_id == MSHR_ID_W'(i))) entry_d[i].state = ST_DONE;
                end
                ST_DONE: begin
                    if (done_fire && (done_id == MSHR_ID_W'(i)))
                        entry_d[i] = pack_l1d_mshr_entry(ST_IDLE, 1'b0, 1'b0, 1'b0, '0);
                end
                default: entry_d[i] = pack_l1d_mshr_entry(ST_IDLE, 1'b0, 1'b0, 1'b0, '0);
            endcase
        end

        err_d = err_q ||
                (evict_ack_vld && (entry_q[evict_ack_id].state != ST_EVICT_WAIT)) ||
                (fill_ack_vld  && (entry_q[fill_ack_id].state  != ST_FILL_WAIT));

        occupancy_d = occupancy_q;
        if (alloc_fire && !done_fire)      occupancy_d = occupancy_q + 1'b1;
        else if (!alloc_fire && done_fire) occupancy_d = occupancy_q - 1'b1;
    end

    // Entry table, occupancy and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSHR_NUM; i++)
                entry_q[i] <= pack_l1d_mshr_entry(ST_IDLE, 1'b0, 1'b0, 1'b0, '0);
            occupancy_q <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < MSHR_NUM; i++)
                entry_q[i] <= entry_d[i];
            occupancy_q <= occupancy_d;
            err_q       <= err_d;
        end
    end

    assign occupancy     = occupancy_q;
    assign err_unexp_ack = err_q;

`ifdef L1D_MSHR_PERF_CNT_EN
    logic [31:0] perf_alloc_cnt_q, perf_alloc_cnt_d;
    logic [31:0] perf_evict_cnt_q, perf_evict_cnt_d;
    logic [31:0] perf_fill_cnt_q,  perf_fill_cnt_d;
    logic [31:0] perf_hzd_cnt_q,   perf_hzd_cnt_d;
    logic        any_hzd;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Event counters; the hazard counter ticks on any cycle with an entry in HZD.
    always_comb begin
        any_hzd = 1'b0;
        for (int i = 0; i < MSHR_NUM; i++)
            if (entry_q[i].state == ST_HZD) any_hzd = 1'b1;
        perf_alloc_cnt_d = sat_inc(perf_alloc_cnt_q, alloc_fire);
        perf_evict_cnt_d = sat_inc(perf_evict_cnt_q, evict_fire);
        perf_fill_cnt_d  = sat_inc(perf_fill_cnt_q, fill_fire);
        perf_hzd_cnt_d   = sat_inc(perf_hzd_cnt_q, any_hzd);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_alloc_cnt_q <= '0;
            perf_evict_cnt_q <= '0;
            perf_fill_cnt_q  <= '0;
            perf_hzd_cnt_q   <= '0;
        end else begin
            perf_alloc_cnt_q <= perf_alloc_cnt_d;
            perf_evict_cnt_q <= perf_evict_cnt_d;
            perf_fill_cnt_q  <= perf_fill_cnt_d;
            perf_hzd_cnt_q   <= perf_hzd_cnt_d;
        end
    end

    assign perf_alloc_cnt     = perf_alloc_cnt_q;
    assign perf_evict_cnt     = perf_evict_cnt_q;
    assign perf_fill_cnt      = perf_fill_cnt_q;
    assign perf_hzd_stall_cnt = perf_hzd_cnt_q;
`endif

endmodule

// File: tb/tb_l1d_mshr_scheduler.sv
// tb_l1d_mshr_scheduler: directed scenarios plus randomized traffic for the
// L1D MSHR scheduler, checked every cycle against a flag-based entry model.
module tb_l1d_mshr_scheduler;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_vld, alloc_rdy, alloc_need_evict, alloc_need_linefill, alloc_hzd_vld;
    logic [W-1:0] alloc_id, alloc_hzd_id;
    logic         evict_req_vld, evict_req_rdy, evict_ack_vld;
    logic [W-1:0] evict_req_id, evict_ack_id;
    logic         fill_req_vld, fill_req_rdy, fill_ack_vld;
    logic [W-1:0] fill_req_id, fill_ack_id;
    logic         done_vld, done_rdy;
    logic [W-1:0] done_id;
    logic [W:0]   occupancy;
    logic         err_unexp_ack;

    always #5 clk = ~clk;

    l1d_mshr_scheduler #(.MSHR_NUM(N)) dut (
        .clk(clk), .rst(rst),
        .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_id(alloc_id),
        .alloc_need_evict(alloc_need_evict), .alloc_need_linefill(alloc_need_linefill),
        .alloc_hzd_vld(alloc_hzd_vld), .alloc_hzd_id(alloc_hzd_id),
        .evict_req_vld(evict_req_vld), .evict_req_rdy(evict_req_rdy), .evict_req_id(evict_req_id),
        .evict_ack_vld(evict_ack_vld), .evict_ack_id(evict_ack_id),
        .fill_req_vld(fill_req_vld), .fill_req_rdy(fill_req_rdy), .fill_req_id(fill_req_id),
        .fill_ack_vld(fill_ack_vld), .fill_ack_id(fill_ack_id),
        .done_vld(done_vld), .done_rdy(done_rdy), .done_id(done_id),
        .occupancy(occupancy), .err_unexp_ack(err_unexp_ack)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: each entry is a set of progress flags rather than a state.
    bit busy[N], ne[N], nf[N], es[N], ed[N], fs[N], fd[N];
    int blk[N];            // id this entry waits to see retire, -1 if none
    int rr[3];             // next-priority index per port (0 evict, 1 fill, 2 done)
    int hold[3];           // id offered but not accepted last cycle, -1 if none
    int m_occ;
    bit m_err;

    task automatic chk(string nm, int act, int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    function automatic bit wants(int k, int i);
        bit free_to_go;
        free_to_go = busy[i] && (blk[i] < 0);
        if (k == 0) return free_to_go && ne[i] && !es[i];
        if (k == 1) return free_to_go && nf[i] && (!ne[i] || ed[i]) && !fs[i];
        return free_to_go && (!ne[i] || ed[i]) && (!nf[i] || fd[i]);
    endfunction

    function automatic int pick(int k);
        if (hold[k] >= 0) return hold[k];
        for (int j = 0; j < N; j++)
            if (wants(k, (rr[k] + j) % N)) return (rr[k] + j) % N;
        return -1;
    endfunction

    function automatic int free_id();
        for (int i = 0; i < N; i++) if (!busy[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            busy[i] = 0; ne[i] = 0; nf[i] = 0; es[i] = 0; ed[i] = 0; fs[i] = 0; fd[i] = 0;
            blk[i] = -1;
        end
        for (int k = 0; k < 3; k++) begin rr[k] = 0; hold[k] = -1; end
        m_occ = 0;
        m_err = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        int g[3];
        bit f[3];
        bit rdyv[3];
        int aid;
        bit afire, hz;
        if (rst) begin model_reset(); return; end
        rdyv[0] = evict_req_rdy; rdyv[1] = fill_req_rdy; rdyv[2] = done_rdy;
        for (int k = 0; k < 3; k++) begin
            g[k] = pick(k);
            f[k] = (g[k] >= 0) && rdyv[k];
        end
        aid   = free_id();
        afire = alloc_vld && (aid >= 0);
        hz    = alloc_hzd_vld && busy[alloc_hzd_id] && !(f[2] && g[2] == int'(alloc_hzd_id));
        if (evict_ack_vld) begin
            if (busy[evict_ack_id] && es[evict_ack_id] && !ed[evict_ack_id]) ed[evict_ack_id] = 1;
            else m_err = 1;
        end
        if (fill_ack_vld) begin
            if (busy[fill_ack_id] && fs[fill_ack_id] && !fd[fill_ack_id]) fd[fill_ack_id] = 1;
            else m_err = 1;
        end
        if (f[0]) begin es[g[0]] = 1; rr[0] = (g[0] + 1) % N; end
        if (f[1]) begin fs[g[1]] = 1; rr[1] = (g[1] + 1) % N; end
        if (f[2]) begin
            busy[g[2]] = 0; ne[g[2]] = 0; nf[g[2]] = 0;
            es[g[2]] = 0; ed[g[2]] = 0; fs[g[2]] = 0; fd[g[2]] = 0;
            for (int i = 0; i < N; i++) if (blk[i] == g[2]) blk[i] = -1;
            rr[2] = (g[2] + 1) % N;
        end
        for (int k = 0; k < 3; k++) hold[k] = (g[k] >= 0 && !rdyv[k]) ? g[k] : -1;
        if (afire) begin
            busy[aid] = 1; ne[aid] = alloc_need_evict; nf[aid] = alloc_need_linefill;
            es[aid] = 0; ed[aid] = 0; fs[aid] = 0; fd[aid] = 0;
            blk[aid] = hz ? int'(alloc_hzd_id) : -1;
        end
        m_occ = m_occ + int'(afire) - int'(f[2]);
    endtask

    // Compare every visible output against the model.
    task automatic check_all();
        int g;
        chk("alloc_rdy", alloc_rdy, free_id() >= 0);
        if (free_id() >= 0) chk("alloc_id", alloc_id, free_id());
        g = pick(0);
        chk("evict_req_vld", evict_req_vld, g >= 0);
        if (g >= 0) chk("evict_req_id", evict_req_id, g);
        g = pick(1);
        chk("fill_req_vld", fill_req_vld, g >= 0);
        if (g >= 0) chk("fill_req_id", fill_req_id, g);
        g = pick(2);
        chk("done_vld", done_vld, g >= 0);
        if (g >= 0) chk("done_id", done_id, g);
        chk("occupancy", occupancy, m_occ);
        chk("err_unexp_ack", err_unexp_ack, m_err);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_inputs();
        alloc_vld = 0; alloc_need_evict = 0; alloc_need_linefill = 0;
        alloc_hzd_vld = 0; alloc_hzd_id = '0;
        evict_req_rdy = 0; evict_ack_vld = 0; evict_ack_id = '0;
        fill_req_rdy = 0; fill_ack_vld = 0; fill_ack_id = '0;
        done_rdy = 0;
    endtask

    task automatic do_alloc(bit e, bit f, bit hv, int hid);
        alloc_vld = 1; alloc_need_evict = e; alloc_need_linefill = f;
        alloc_hzd_vld = hv; alloc_hzd_id = W'(hid);
        tick();
        alloc_vld = 0; alloc_hzd_vld = 0;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int q[$];
        model_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        chk("reset_occ", occupancy, 0);
        chk("reset_err", err_unexp_ack, 0);
        chk("reset_rdy", alloc_rdy, 1);

        // Hit: retire one cycle after allocation.
        chk("t1_alloc_id", alloc_id, 0);
        do_alloc(0, 0, 0, 0);
        chk("t1_done_vld", done_vld, 1);
        chk("t1_done_id", done_id, 0);
        chk("t1_occ1", occupancy, 1);
        done_rdy = 1; tick(); done_rdy = 0;
        chk("t1_occ0", occupancy, 0);

        // Dirty miss with evict port stalled for three cycles.
        do_alloc(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_evict_hold_vld", evict_req_vld, 1);
            chk("t2_evict_hold_id", evict_req_id, 0);
            tick();
        end
        evict_req_rdy = 1; tick(); evict_req_rdy = 0;
        chk("t2_evict_gone", evict_req_vld, 0);
        chk("t2_no_fill_yet", fill_req_vld, 0);
        evict_ack_vld = 1; evict_ack_id = 0; tick(); evict_ack_vld = 0;
        chk("t2_fill_vld", fill_req_vld, 1);
        chk("t2_fill_id", fill_req_id, 0);
        fill_req_rdy = 1; tick(); fill_req_rdy = 0;
        fill_ack_vld = 1; fill_ack_id = 0; tick(); fill_ack_vld = 0;
        chk("t2_done_vld", done_vld, 1);
        chk("t2_done_id", done_id, 0);
        done_rdy = 1; tick(); done_rdy = 0;

        // Hazard: id1 waits for id0 to retire.
        do_alloc(0, 1, 0, 0);
        fill_req_rdy = 1; tick(); fill_req_rdy = 0;
        chk("t3_alloc_id", alloc_id, 1);
        do_alloc(0, 1, 1, 0);
        tick();
        chk("t3_blocked_fill", fill_req_vld, 0);
        chk("t3_blocked_done", done_vld, 0);
        fill_ack_vld = 1; fill_ack_id = 0; tick(); fill_ack_vld = 0;
        chk("t3_id0_done", done_id, 0);
        chk("t3_still_blocked", fill_req_vld, 0);
        done_rdy = 1; tick(); done_rdy = 0;
        chk("t3_id1_fill_vld", fill_req_vld, 1);
        chk("t3_id1_fill_id", fill_req_id, 1);
        fill_req_rdy = 1; tick(); fill_req_rdy = 0;
        fill_ack_vld = 1; fill_ack_id = 1; tick(); fill_ack_vld = 0;
        done_rdy = 1; tick(); done_rdy = 0;

        // Fill all entries; only id5 can retire.
        for (int i = 0; i < N; i++) begin
            chk("t4_alloc_seq", alloc_id, i);
            do_alloc(0, i != 5, 0, 0);
        end
        chk("t4_full_rdy", alloc_rdy, 0);
        chk("t4_full_occ", occupancy, 8);
        chk("t4_done_id", done_id, 5);
        alloc_vld = 1; done_rdy = 1; tick(); alloc_vld = 0; done_rdy = 0;
        chk("t4_occ7", occupancy, 7);
        chk("t4_reuse_rdy", alloc_rdy, 1);
        chk("t4_reuse_id", alloc_id, 5);
        do_alloc(1, 0, 0, 0);
        chk("t4_refull_occ", occupancy, 8);
        do_reset();
        chk("t4_rst_occ", occupancy, 0);

        // Round-robin over evict requests from ids 0,2,3.
        do_alloc(1, 0, 0, 0);
        do_alloc(0, 1, 0, 0);
        do_alloc(1, 0, 0, 0);
        do_alloc(1, 0, 0, 0);
        evict_req_rdy = 1;
        chk("t5_g0", evict_req_id, 0); tick();
        chk("t5_g2", evict_req_id, 2); tick();
        chk("t5_g3", evict_req_id, 3); tick();
        chk("t5_empty", evict_req_vld, 0);
        evict_req_rdy = 0;
        do_reset();

        // Unexpected ack, stickiness, and stale ack after reset.
        fill_ack_vld = 1; fill_ack_id = 4; tick(); fill_ack_vld = 0;
        chk("t6_err_set", err_unexp_ack, 1);
        tick(); tick();
        chk("t6_err_sticky", err_unexp_ack, 1);
        do_reset();
        chk("t6_err_clr", err_unexp_ack, 0);
        chk("t6_idle_occ", occupancy, 0);
        do_alloc(1, 0, 0, 0);
        evict_req_rdy = 1; tick(); evict_req_rdy = 0;
        do_reset();
        evict_ack_vld = 1; evict_ack_id = 0; tick(); evict_ack_vld = 0;
        chk("t6_stale_ack", err_unexp_ack, 1);
        do_reset();

        // Random traffic with legal acknowledgements and occasional reset.
        for (int c = 0; c < 4000; c++) begin
            alloc_vld           = $urandom_range(0, 1);
            alloc_need_evict    = ($urandom_range(0, 2) == 0);
            alloc_need_linefill = ($urandom_range(0, 2) != 0);
            alloc_hzd_vld       = ($urandom_range(0, 2) == 0);
            alloc_hzd_id        = W'($urandom_range(0, N - 1));
            evict_req_rdy       = ($urandom_range(0, 3) != 0);
            fill_req_rdy        = ($urandom_range(0, 3) != 0);
            done_rdy            = ($urandom_range(0, 3) != 0);
            q.delete();
            for (int i = 0; i < N; i++) if (busy[i] && es[i] && !ed[i]) q.push_back(i);
            evict_ack_vld = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            evict_ack_id  = (q.size() > 0) ? W'(q[$urandom_range(0, q.size() - 1)]) : '0;
            q.delete();
            for (int i = 0; i < N; i++) if (busy[i] && fs[i] && !fd[i]) q.push_back(i);
            fill_ack_vld = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            fill_ack_id  = (q.size() > 0) ? W'(q[$urandom_range(0, q.size() - 1)]) : '0;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0;
        clear_inputs();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
